// File: rtl/ff_d_rr_ctrl.sv
// Round-robin arbiter and load sequencer for one shared D-register.
// The winning requester loads the register up to HOLD_MAX times per grant.
module ff_d_rr_ctrl #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*DW-1:0]      i_data,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [DW-1:0]            o_data,
    output logic                     o_valid,
    output logic [$clog2(N_REQ)-1:0] o_owner
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [OW-1:0]   pick;
    int unsigned     idx;
    logic [DW-1:0]   data_arr [N_REQ];

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            data_arr[k] = i_data[k*DW +: DW];
        end
    end

    // First active request scanning from ptr upward with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!found && i_req[OW'(idx)]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            o_gnt   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_owner <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (found) begin
                        o_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        o_data  <= data_arr[pick];
                        o_valid <= 1'b1;
                        o_owner <= pick;
                        cnt     <= CW'(1);
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (i_req[o_owner] && (cnt < CW'(HOLD_MAX))) begin
                        o_data  <= data_arr[o_owner];
                        o_valid <= 1'b1;
                        cnt     <= cnt + CW'(1);
                    end else begin
                        o_gnt   <= '0;
                        o_valid <= 1'b0;
                        ptr     <= (o_owner == OW'(N_REQ-1)) ? '0 : o_owner + OW'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_d_rr_ctrl.sv
// Bench for ff_d_rr_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model; a second small build checks HOLD_MAX=1, N_REQ=2.
module tb_ff_d_rr_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   odata;
    logic            valid;
    logic [1:0]      owner;

    logic [1:0]      req2 = '0;
    logic [15:0]     data2 = '0;
    logic [1:0]      gnt2;
    logic [7:0]      odata2;
    logic            valid2;
    logic            owner2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              busy = 0;
    int              own = 0, loads = 0, ptr = 0;
    logic [N-1:0]    e_gnt = '0;
    logic [DW-1:0]   e_data = '0;
    logic            e_valid = 1'b0;
    logic [1:0]      e_owner = '0;

    always #5 clk = ~clk;

    ff_d_rr_ctrl #(.N_REQ(N), .DW(DW), .HOLD_MAX(H)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_data(data),
        .o_gnt(gnt), .o_data(odata), .o_valid(valid), .o_owner(owner)
    );

    ff_d_rr_ctrl #(.N_REQ(2), .DW(8), .HOLD_MAX(1)) dut2 (
        .clk(clk), .rst(rst), .i_req(req2), .i_data(data2),
        .o_gnt(gnt2), .o_data(odata2), .o_valid(valid2), .o_owner(owner2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] one;
        one = 1;
        if (rst) begin
            busy = 0; loads = 0; ptr = 0; own = 0;
            e_gnt = '0; e_data = '0; e_valid = 1'b0; e_owner = '0;
        end else if (!busy) begin
            e_valid = 1'b0;
            for (int j = 0; j < N; j++) begin
                int k;
                k = (ptr + j) % N;
                if (!busy && req[k]) begin
                    busy = 1; own = k; loads = 1;
                    e_gnt = one << k; e_data = data[k*DW +: DW];
                    e_valid = 1'b1; e_owner = 2'(k);
                end
            end
        end else if (req[own] && loads < H) begin
            loads++;
            e_data = data[own*DW +: DW];
            e_valid = 1'b1;
        end else begin
            busy = 0;
            e_gnt = '0;
            e_valid = 1'b0;
            ptr = (own + 1) % N;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("data", 32'(odata), 32'(e_data));
        check("valid", 32'(valid), 32'(e_valid));
        check("owner", 32'(owner), 32'(e_owner));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Reset, then idle with no requests
        req = '0;
        do_reset();
        repeat (3) cycle();

        // Lone requester 2 held: 4 loads, gap, regrant
        data = 32'h00A5_0000;
        req  = 4'b0100;
        repeat (12) cycle();

        // All requesting: rotation 0,1,2,3,0 with fresh data each cycle
        req = '0;
        do_reset();
        req = 4'b1111;
        repeat (26) begin
            data = $urandom;
            cycle();
        end

        // Owner 1 drops after 2 loads while 3 waits
        req = '0;
        do_reset();
        req = 4'b1010;
        data = 32'h44_33_22_11;
        cycle();
        data = 32'h48_37_26_15;
        cycle();
        req = 4'b1000;
        data = 32'h99_88_77_66;
        repeat (4) cycle();

        // Reset mid-ownership, then pointer restarts at 0
        req = '0;
        do_reset();
        req = 4'b0100;
        data = 32'h00C3_0000;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b1010;
        repeat (3) cycle();

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            data = $urandom;
            cycle();
        end
        rst = 1'b0;

        // Small build: alternating single loads 0,1,0,1 with gaps
        req = '0;
        do_reset();
        req2  = 2'b11;
        data2 = 16'h22_11;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            if (c % 2 == 1) begin
                int w;
                w = ((c - 1) / 2) % 2;
                check("gnt2", 32'(gnt2), 32'(1 << w));
                check("valid2", 32'(valid2), 32'd1);
                check("owner2", 32'(owner2), 32'(w));
                check("data2", 32'(odata2), (w == 1) ? 32'h22 : 32'h11);
            end else begin
                check("gnt2_gap", 32'(gnt2), 32'd0);
                check("valid2_gap", 32'(valid2), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
